ram16bit_wb_arb: RTL
====================

# ram16bit_wb_arb

Two-master Wishbone arbiter that shares one 16-bit single-port RAM slave between an instruction-fetch master (m0) and a data master (m1). It sits between the core's bus masters and the RAM wrapper. It grants the slave to one master at a time with round-robin fairness and holds each grant for the whole `cyc` tenure. It muxes address, data and strobes to the slave, and routes `ack` back to the granted master only. A watchdog returns `err` when the slave fails to acknowledge.

## Interface
- `TIMEOUT`, 16: number of cycles a granted strobe may wait for ack before `err`; legal range 2–65535.
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `m0_wb_adr_i` / `m1_wb_adr_i`  in  32  master address.
- `m0_wb_dat_i` / `m1_wb_dat_i`  in  16  master write data.
- `m0_wb_sel_i` / `m1_wb_sel_i`  in  2  byte selects.
- `m0_wb_we_i` / `m1_wb_we_i`  in  1  write enable.
- `m0_wb_cyc_i` / `m1_wb_cyc_i`  in  1  bus request / tenure.
- `m0_wb_stb_i` / `m1_wb_stb_i`  in  1  transfer strobe.
- `m0_wb_dat_o` / `m1_wb_dat_o`  out  16  read data; the slave data is broadcast to both masters.
- `m0_wb_ack_o` / `m1_wb_ack_o`  out  1  ack, gated by grant.
- `m0_wb_err_o` / `m1_wb_err_o`  out  1  timeout error, gated by grant.
- `s_wb_adr_o`  out  32  muxed address to RAM.
- `s_wb_dat_o`  out  16  muxed write data.
- `s_wb_sel_o`  out  2  muxed selects.
- `s_wb_we_o`  out  1  muxed write enable.
- `s_wb_cyc_o` / `s_wb_stb_o`  out  1  muxed cycle/strobe; low when no grant or during an err cycle.
- `s_wb_dat_i`  in  16  RAM read data.
- `s_wb_ack_i`  in  1  RAM ack.
- `gnt_o`  out  2  one-hot current grant, for debug and perf counters.

## Operation
- State register is one of IDLE, GNT0 or GNT1. A `last` register holds the master granted most recently.
- IDLE, no `cyc` asserted: stay in IDLE.
- IDLE, only mN `cyc` asserted: go to GNTN.
- IDLE, both `cyc` asserted: grant the master that is not `last`.
- GNTN while mN `cyc`=1: stay in GNTN, so a burst or read-modify-write is never split.
- GNTN when mN `cyc`=0:
  - If the other master's `cyc`=1, hand off directly to GNT(other). There is no IDLE bubble.
  - Otherwise go to IDLE.
- `last` updates on every entry into GNT0 or GNT1.
- Slave outputs come from the granted master via the registered state. In IDLE, `s_wb_cyc_o`, `s_wb_stb_o` and `s_wb_we_o` are 0. In IDLE, address, data and select are don't-care and driven from m0.
- `mN_wb_ack_o = s_wb_ack_i & (state==GNTN)`. The non-granted master never sees ack or err.
- Watchdog counter, 16 bits:
  - Clears when no strobe is granted, on any `s_wb_ack_i`, or on a grant change.
  - Otherwise increments each cycle that the granted `stb & cyc` is high.
  - When the count reaches `TIMEOUT-1`, `mN_wb_err_o` pulses for exactly one cycle. During that cycle `s_wb_stb_o` is forced to 0, and the counter then clears.
- If ack and timeout occur in the same cycle, ack wins and no err is raised.

## Timing
- Reset (`rst_i`=0) drives all of the following immediately, asynchronously:
  - state = IDLE and `last` = 1, so m0 wins the first tie.
  - Counter = 0 and `gnt_o` = 2'b00.
  - All `s_wb_cyc_o`, `s_wb_stb_o`, ack and err outputs = 0.
- Reset asserted mid-transfer aborts the transfer. No ack or err is delivered.
- Grant latency is one cycle. For a request seen in IDLE at edge N, grant and slave strobe are valid after edge N+1. With the registered-ack RAM, the master's ack arrives after edge N+2.
- Under a continuous grant with `stb` held, the RAM acks every cycle after the first.
- Handoff: mN drops `cyc` at edge K while the other master is requesting. The other master is granted after edge K+1, and its strobe reaches the slave in that cycle.
- A master that holds `cyc` indefinitely starves the other master. This is the intended lock semantics.

## Test plan
- Single master: m0 reads address 0x10 with `cyc`/`stb` at cycle 0. `gnt_o`=01 at cycle 1, `m0_wb_ack_o`=1 at cycle 2 with RAM data 0xBEEF, and `m1_wb_ack_o` stays 0 throughout.
- Tie after reset: m0 and m1 request together. m0 is granted first. When m0 drops `cyc`, m1 is granted on the next cycle with no IDLE. The next tie goes to m0, because `last`=1.
- Burst lock: m1 holds `cyc` for 4 back-to-back writes of 0x0001–0x0004 while m0 requests. All 4 writes complete before `gnt_o` becomes 01, and readback returns 0x0001–0x0004.
- Timeout: slave `ack` is tied to 0 and m0 strobes with `TIMEOUT`=4. `m0_wb_err_o` pulses exactly once, 4 cycles after grant. `s_wb_stb_o` is 0 in that cycle and the counter restarts.
- Ack/timeout collision: ack arrives exactly on cycle `TIMEOUT-1`. Ack=1 and err stays 0.
- Async reset mid-burst: `rst_i` is pulled low between clock edges during a GNT1 write. All outputs drop to their reset values without waiting for a clock edge, and after release the first tie goes to m0.

Source files
------------

// File: rtl/ram16bit_wb_arb.sv
// Two-master Wishbone arbiter in front of a single-port 16-bit RAM.
// Round-robin between m0 (instruction fetch) and m1 (data). A grant is held
// for the full cyc tenure. A watchdog returns err to the granted master
// when the slave does not acknowledge a strobe in time.
module ram16bit_wb_arb #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // master 0
  input  logic [31:0] m0_wb_adr_i,
  input  logic [15:0] m0_wb_dat_i,
  input  logic [1:0]  m0_wb_sel_i,
  input  logic        m0_wb_we_i,
  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_stb_i,
  output logic [15:0] m0_wb_dat_o,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_err_o,
  // master 1
  input  logic [31:0] m1_wb_adr_i,
  input  logic [15:0] m1_wb_dat_i,
  input  logic [1:0]  m1_wb_sel_i,
  input  logic        m1_wb_we_i,
  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_stb_i,
  output logic [15:0] m1_wb_dat_o,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_err_o,
  // slave
  output logic [31:0] s_wb_adr_o,
  output logic [15:0] s_wb_dat_o,
  output logic [1:0]  s_wb_sel_o,
  output logic        s_wb_we_o,
  output logic        s_wb_cyc_o,
  output logic        s_wb_stb_o,
  input  logic [15:0] s_wb_dat_i,
  input  logic        s_wb_ack_i,
  // debug
  output logic [1:0]  gnt_o
);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        last;      // master granted most recently (1 = m1)
  logic [15:0] cnt;       // cycles the granted strobe has waited for ack
  logic        err_q;     // one-cycle timeout pulse

  logic        sel0;
  logic        sel1;
  logic        g_cyc;
  logic        g_stb;
  logic        g_we;

  assign sel0  = (state == GNT0);
  assign sel1  = (state == GNT1);
  assign g_cyc = (sel0 & m0_wb_cyc_i) | (sel1 & m1_wb_cyc_i);
  assign g_stb = (sel0 & m0_wb_cyc_i & m0_wb_stb_i) | (sel1 & m1_wb_cyc_i & m1_wb_stb_i);
  assign g_we  = (sel0 & m0_wb_we_i) | (sel1 & m1_wb_we_i);

  // Arbitration FSM: round-robin on ties, grant held while cyc stays high,
  // direct handoff to a waiting master without passing through IDLE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_wb_cyc_i && (!m1_wb_cyc_i || last)) begin
            state <= GNT0;
            last  <= 1'b0;
          end else if (m1_wb_cyc_i) begin
            state <= GNT1;
            last  <= 1'b1;
          end
        end
        GNT0: begin
          if (!m0_wb_cyc_i) begin
            if (m1_wb_cyc_i) begin
              state <= GNT1;
              last  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        GNT1: begin
          if (!m1_wb_cyc_i) begin
            if (m0_wb_cyc_i) begin
              state <= GNT0;
              last  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Watchdog: counts unacknowledged granted strobe cycles. A grant can only
  // change after the owner drops cyc, which already clears the count, so no
  // separate grant-change term is needed. Ack in the final cycle wins over err.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt   <= 16'd0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (!g_stb || s_wb_ack_i || err_q) begin
        cnt <= 16'd0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= 16'd0;
        err_q <= 1'b1;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  // Slave side follows the registered grant; address/data/select default to m0.
  assign s_wb_adr_o = sel1 ? m1_wb_adr_i : m0_wb_adr_i;
  assign s_wb_dat_o = sel1 ? m1_wb_dat_i : m0_wb_dat_i;
  assign s_wb_sel_o = sel1 ? m1_wb_sel_i : m0_wb_sel_i;
  assign s_wb_we_o  = g_we;
  assign s_wb_cyc_o = g_cyc & ~err_q;
  assign s_wb_stb_o = g_stb & ~err_q;

  // Read data is broadcast; ack and err reach only the granted master.
  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;
  assign m0_wb_ack_o = s_wb_ack_i & sel0;
  assign m1_wb_ack_o = s_wb_ack_i & sel1;
  assign m0_wb_err_o = err_q & sel0;
  assign m1_wb_err_o = err_q & sel1;

  assign gnt_o = state;

endmodule
